// File: rtl/coco3_kbd_pkg.sv
// Purpose : shared CoCo3 keyboard types, matrix positions and PS/2 set-2 lookup.
// Latency : n/a (types and a combinational lookup function only).
// Backpr. : n/a.
// Contents: ROWS/COLS, key_pos_t, KP_* named positions, ps2_to_pos(), pos_idx().
package coco3_kbd_pkg;

  localparam int ROWS = 7;
  localparam int COLS = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  localparam key_pos_t KP_NONE  = '{hit: 1'b0, row: 3'd0, col: 3'd0};
  localparam key_pos_t KP_UP    = '{hit: 1'b1, row: 3'd3, col: 3'd3};
  localparam key_pos_t KP_DOWN  = '{hit: 1'b1, row: 3'd3, col: 3'd4};
  localparam key_pos_t KP_LEFT  = '{hit: 1'b1, row: 3'd3, col: 3'd5};
  localparam key_pos_t KP_RIGHT = '{hit: 1'b1, row: 3'd3, col: 3'd6};
  localparam key_pos_t KP_ENTER = '{hit: 1'b1, row: 3'd6, col: 3'd0};
  localparam key_pos_t KP_CLEAR = '{hit: 1'b1, row: 3'd6, col: 3'd1};
  localparam key_pos_t KP_BREAK = '{hit: 1'b1, row: 3'd6, col: 3'd2};
  localparam key_pos_t KP_ALT   = '{hit: 1'b1, row: 3'd6, col: 3'd3};
  localparam key_pos_t KP_CTRL  = '{hit: 1'b1, row: 3'd6, col: 3'd4};
  localparam key_pos_t KP_F1    = '{hit: 1'b1, row: 3'd6, col: 3'd5};
  localparam key_pos_t KP_F2    = '{hit: 1'b1, row: 3'd6, col: 3'd6};
  localparam key_pos_t KP_SHIFT = '{hit: 1'b1, row: 3'd6, col: 3'd7};

  // Matrix bit index row*8+col is simply the concatenation {row, col}.
  function automatic logic [5:0] pos_idx(input key_pos_t p);
    return {p.row, p.col};
  endfunction

  function automatic key_pos_t kp(input int r, input int c);
    key_pos_t p;
    p.hit = 1'b1;
    p.row = 3'(r);
    p.col = 3'(c);
    return p;
  endfunction

  function automatic key_pos_t ps2_to_pos(input logic ext, input logic [7:0] code);
    key_pos_t p;
    p = KP_NONE;
    if (!ext) begin
      case (code)
        8'h54: p = kp(0, 0);  8'h1C: p = kp(0, 1);  8'h32: p = kp(0, 2);  8'h21: p = kp(0, 3);
        8'h23: p = kp(0, 4);  8'h24: p = kp(0, 5);  8'h2B: p = kp(0, 6);  8'h34: p = kp(0, 7);
        8'h33: p = kp(1, 0);  8'h43: p = kp(1, 1);  8'h3B: p = kp(1, 2);  8'h42: p = kp(1, 3);
        8'h4B: p = kp(1, 4);  8'h3A: p = kp(1, 5);  8'h31: p = kp(1, 6);  8'h44: p = kp(1, 7);
        8'h4D: p = kp(2, 0);  8'h15: p = kp(2, 1);  8'h2D: p = kp(2, 2);  8'h1B: p = kp(2, 3);
        8'h2C: p = kp(2, 4);  8'h3C: p = kp(2, 5);  8'h2A: p = kp(2, 6);  8'h1D: p = kp(2, 7);
        8'h22: p = kp(3, 0);  8'h35: p = kp(3, 1);  8'h1A: p = kp(3, 2);  8'h29: p = kp(3, 7);
        8'h45: p = kp(4, 0);  8'h16: p = kp(4, 1);  8'h1E: p = kp(4, 2);  8'h26: p = kp(4, 3);
        8'h25: p = kp(4, 4);  8'h2E: p = kp(4, 5);  8'h36: p = kp(4, 6);  8'h3D: p = kp(4, 7);
        8'h3E: p = kp(5, 0);  8'h46: p = kp(5, 1);  8'h52: p = kp(5, 2);  8'h4C: p = kp(5, 3);
        8'h41: p = kp(5, 4);  8'h4E: p = kp(5, 5);  8'h49: p = kp(5, 6);  8'h4A: p = kp(5, 7);
        8'h5A: p = KP_ENTER;
        8'h76: p = KP_BREAK;
        8'h66: p = KP_LEFT;   // Backspace doubles as cursor-left, as on the real machine
        8'h05: p = KP_F1;
        8'h06: p = KP_F2;
        8'h11: p = KP_ALT;
        8'h14: p = KP_CTRL;
        8'h12, 8'h59: p = KP_SHIFT;
        default: p = KP_NONE;
      endcase
    end else begin
      case (code)
        8'h75: p = KP_UP;
        8'h72: p = KP_DOWN;
        8'h6B: p = KP_LEFT;
        8'h74: p = KP_RIGHT;
        8'h5A: p = KP_ENTER;
        8'h6C: p = KP_CLEAR;
        8'h11: p = KP_ALT;
        8'h14: p = KP_CTRL;
        default: p = KP_NONE;  // includes E0 71 (Del): never enters the matrix
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/coco3_row_mux.sv
// Purpose : reduces the key matrix against active-low column strobes to active-low row returns.
// Latency : 1 cycle from matrix or col_strobe_n change to row_n.
// Backpr. : none; purely follows its inputs every cycle.
// Ports   : clk_sys, reset (sync, high) | matrix[ROWS*COLS], col_strobe_n[COLS] in | row_n[ROWS] out.
module coco3_row_mux #(
  parameter int ROWS = 7,
  parameter int COLS = 8
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] matrix,
  input  logic [COLS-1:0]      col_strobe_n,
  output logic [ROWS-1:0]      row_n
);

  logic [ROWS-1:0] row_d;

  // A row reads low when any pressed key in it sits on a column being driven low.
  always_comb begin
    row_d = '1;
    for (int r = 0; r < ROWS; r++) begin
      row_d[r] = ~(|(matrix[r*COLS +: COLS] & ~col_strobe_n));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) row_n <= '1;
    else       row_n <= row_d;
  end

endmodule

// File: rtl/coco3_ps2_matrix.sv
// Purpose : converts MiSTer ps2_key events into the CoCo3 8x7 keyboard matrix plus Ctrl+Alt+Del request.
// Latency : event -> matrix/kbd_reset_req 2 cycles, event -> row_n 3 cycles; fully pipelined.
// Backpr. : none; one event per cycle is accepted, clear_keys/reset drop any in-flight event.
// Ports   : clk_sys, reset, clear_keys, ps2_key[11], col_strobe_n[8] in | row_n[7], matrix[56], kbd_reset_req out.
module coco3_ps2_matrix
  import coco3_kbd_pkg::*;
#(
  parameter bit DEBOUNCE_EN = 1'b0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  input  logic [COLS-1:0]      col_strobe_n,
  output logic [ROWS-1:0]      row_n,
  output logic [ROWS*COLS-1:0] matrix,
  output logic                 kbd_reset_req,
  input  logic                 clear_keys
);

  logic       tog_q;
  logic       ev;
  logic       dup;
  logic       last_vld;
  logic [9:0] last_key;

  logic       s1_vld;
  logic       s1_pressed;
  logic       s1_ext;
  logic [7:0] s1_code;

  logic [ROWS*COLS-1:0] matrix_q, matrix_d;
  logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;
  logic lshift_d, rshift_d, lctrl_d, rctrl_d, lalt_d, ralt_d;
  logic req_d;
  key_pos_t pos;
  logic [5:0] idx;

  // ---------------- Stage 1: event detect and capture ----------------
  assign ev  = ps2_key[10] ^ tog_q;
  // Unmapped codes also update last_key, so they break a repeat sequence.
  assign dup = DEBOUNCE_EN && last_vld && (last_key == ps2_key[9:0]);

  always_ff @(posedge clk_sys) begin
    // Tracking the toggle unconditionally means reset/clear resync it for free.
    tog_q      <= ps2_key[10];
    s1_pressed <= ps2_key[9];
    s1_ext     <= ps2_key[8];
    s1_code    <= ps2_key[7:0];
    if (reset || clear_keys) begin
      s1_vld   <= 1'b0;
      last_vld <= 1'b0;
      last_key <= '0;
    end else begin
      s1_vld <= ev && !dup;
      if (ev) begin
        last_vld <= 1'b1;
        last_key <= ps2_key[9:0];
      end
    end
  end

  // ---------------- Stage 2: lookup and matrix update ----------------
  always_comb begin
    matrix_d = matrix_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    lalt_d   = lalt_q;
    ralt_d   = ralt_q;
    req_d    = 1'b0;
    pos      = ps2_to_pos(s1_ext, s1_code);
    idx      = pos_idx(pos);

    if (s1_vld && pos.hit) begin
      if (pos == KP_SHIFT) begin
        if (s1_code == 8'h12) lshift_d = s1_pressed;
        else                  rshift_d = s1_pressed;
      end else if (pos == KP_CTRL) begin
        if (s1_ext) rctrl_d = s1_pressed;
        else        lctrl_d = s1_pressed;
      end else if (pos == KP_ALT) begin
        if (s1_ext) ralt_d = s1_pressed;
        else        lalt_d = s1_pressed;
      end else begin
        matrix_d[idx] = s1_pressed;
      end
    end

    // Del is judged against the modifiers already held, not ones arriving with it.
    if (s1_vld && s1_pressed && s1_ext && (s1_code == 8'h71) &&
        (lctrl_q || rctrl_q) && (lalt_q || ralt_q)) begin
      req_d = 1'b1;
    end

    // Modifier keys show as pressed while either physical key is down.
    matrix_d[pos_idx(KP_SHIFT)] = lshift_d || rshift_d;
    matrix_d[pos_idx(KP_CTRL)]  = lctrl_d  || rctrl_d;
    matrix_d[pos_idx(KP_ALT)]   = lalt_d   || ralt_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset || clear_keys) begin
      matrix_q      <= '0;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      lctrl_q       <= 1'b0;
      rctrl_q       <= 1'b0;
      lalt_q        <= 1'b0;
      ralt_q        <= 1'b0;
      kbd_reset_req <= 1'b0;
    end else begin
      matrix_q      <= matrix_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      lctrl_q       <= lctrl_d;
      rctrl_q       <= rctrl_d;
      lalt_q        <= lalt_d;
      ralt_q        <= ralt_d;
      kbd_reset_req <= req_d;
    end
  end

  assign matrix = matrix_q;

  // ---------------- Stage 3: row return ----------------
  coco3_row_mux #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_row_mux (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .matrix       (matrix_q),
    .col_strobe_n (col_strobe_n),
    .row_n        (row_n)
  );

endmodule

// File: tb/tb_coco3_ps2_matrix.sv
// Purpose : directed self-checking bench for coco3_ps2_matrix (default and debounced builds).
// Latency : n/a.
// Backpr. : n/a.
module tb_coco3_ps2_matrix;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  col_strobe_n;
  logic        clear_keys;
  logic [6:0]  row_n, row_n_db;
  logic [55:0] matrix, matrix_db;
  logic        kbd_reset_req, kbd_reset_req_db;

  logic tog;
  int   checks = 0;
  int   failures = 0;
  int   pulses = 0;
  int   pulses_db = 0;

  always #5 clk_sys = ~clk_sys;

  coco3_ps2_matrix #(.DEBOUNCE_EN(1'b0)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .col_strobe_n(col_strobe_n),
    .row_n(row_n), .matrix(matrix), .kbd_reset_req(kbd_reset_req), .clear_keys(clear_keys)
  );

  coco3_ps2_matrix #(.DEBOUNCE_EN(1'b1)) dut_db (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .col_strobe_n(col_strobe_n),
    .row_n(row_n_db), .matrix(matrix_db), .kbd_reset_req(kbd_reset_req_db), .clear_keys(clear_keys)
  );

  always @(negedge clk_sys) begin
    if (kbd_reset_req)    pulses++;
    if (kbd_reset_req_db) pulses_db++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One event per call; consecutive calls land on consecutive cycles.
  task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
    @(posedge clk_sys); #1;
    tog = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_clear();
    @(posedge clk_sys); #1;
    clear_keys = 1'b1;
    @(posedge clk_sys); #1;
    clear_keys = 1'b0;
  endtask

  // {ext, code} and expected matrix bit (-1 = no change)
  logic [8:0] map_key [17];
  int         map_bit [17];

  initial begin
    int base, base_db;
    map_key = '{9'h01C, 9'h045, 9'h05A, 9'h15A, 9'h076, 9'h16C, 9'h066, 9'h005, 9'h006,
                9'h04C, 9'h052, 9'h054, 9'h04A, 9'h175, 9'h075, 9'h01A, 9'h029};
    map_bit = '{1, 32, 48, 48, 50, 49, 29, 53, 54, 43, 42, 0, 47, 27, -1, 26, 31};

    tog = 1'b0;
    ps2_key = 11'h000;
    col_strobe_n = 8'hFF;
    clear_keys = 1'b0;
    reset = 1'b1;
    wait_cyc(3);
    check("reset_matrix", 64'(matrix), 64'h0);
    check("reset_row_n", 64'(row_n), 64'h7F);
    check("reset_req", 64'(kbd_reset_req), 64'h0);
    reset = 1'b0;
    wait_cyc(2);
    check("no_spurious", 64'(matrix), 64'h0);

    // A make, latency to matrix and row_n
    col_strobe_n = 8'hFD;
    send(1'b1, 1'b0, 8'h1C);
    wait_cyc(2);
    check("a_matrix_n2", 64'(matrix), 64'h2);
    check("a_row_n_n2", 64'(row_n), 64'h7F);
    wait_cyc(1);
    check("a_row_n_n3", 64'(row_n), 64'h7E);
    col_strobe_n = 8'hFB;
    wait_cyc(1);
    check("a_other_col", 64'(row_n), 64'h7F);
    send(1'b0, 1'b0, 8'h1C);
    wait_cyc(3);
    check("a_break", 64'(matrix), 64'h0);

    // Independent shift flags
    send(1'b1, 1'b0, 8'h12);
    send(1'b1, 1'b0, 8'h59);
    send(1'b0, 1'b0, 8'h12);
    wait_cyc(3);
    check("shift_held", 64'(matrix), 64'h1 << 55);
    send(1'b0, 1'b0, 8'h59);
    wait_cyc(3);
    check("shift_released", 64'(matrix), 64'h0);

    // Ctrl+Alt+Del
    base = pulses;
    send(1'b1, 1'b0, 8'h14);
    send(1'b1, 1'b0, 8'h11);
    send(1'b1, 1'b1, 8'h71);
    wait_cyc(2);
    check("cad_req_high", 64'(kbd_reset_req), 64'h1);
    wait_cyc(1);
    check("cad_req_low", 64'(kbd_reset_req), 64'h0);
    wait_cyc(2);
    check("cad_pulse_count", 64'(pulses - base), 64'h1);
    check("cad_matrix", 64'(matrix), (64'h1 << 51) | (64'h1 << 52));
    send(1'b0, 1'b0, 8'h14);
    send(1'b0, 1'b0, 8'h11);
    send(1'b0, 1'b1, 8'h71);
    wait_cyc(3);
    check("cad_released", 64'(matrix), 64'h0);

    // Back-to-back A then B
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h32);
    col_strobe_n = 8'hF9;
    wait_cyc(3);
    check("ab_matrix", 64'(matrix), 64'h6);
    check("ab_row_n", 64'(row_n), 64'h7E);

    // clear_keys coincident with an S make
    send(1'b1, 1'b0, 8'h29);
    wait_cyc(3);
    check("hold_space", 64'(matrix), 64'h6 | (64'h1 << 31));
    @(posedge clk_sys); #1;
    tog = ~tog;
    ps2_key = {tog, 1'b1, 1'b0, 8'h1B};
    clear_keys = 1'b1;
    @(posedge clk_sys); #1;
    clear_keys = 1'b0;
    wait_cyc(3);
    check("clear_matrix", 64'(matrix), 64'h0);
    check("clear_row_n", 64'(row_n), 64'h7F);

    // Repeated Del: two requests without debounce, one with
    col_strobe_n = 8'hFF;
    send(1'b1, 1'b0, 8'h14);
    send(1'b1, 1'b1, 8'h11);
    base = pulses;
    base_db = pulses_db;
    send(1'b1, 1'b1, 8'h71);
    send(1'b1, 1'b1, 8'h71);
    wait_cyc(4);
    check("del_twice_plain", 64'(pulses - base), 64'h2);
    check("del_twice_db", 64'(pulses_db - base_db), 64'h1);
    check("altgr_ctrl_db", 64'(matrix_db), (64'h1 << 51) | (64'h1 << 52));
    pulse_clear();

    // Debounced repeat make then break
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h1C);
    wait_cyc(3);
    check("db_make", 64'(matrix_db), 64'h2);
    send(1'b0, 1'b0, 8'h1C);
    wait_cyc(3);
    check("db_break", 64'(matrix_db), 64'h0);

    // Fixed map table
    for (int i = 0; i < 17; i++) begin
      pulse_clear();
      send(1'b1, map_key[i][8], map_key[i][7:0]);
      wait_cyc(2);
      check($sformatf("map_%0d", i), 64'(matrix),
            (map_bit[i] < 0) ? 64'h0 : (64'h1 << map_bit[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
